// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the two-master data memory arbiter:
//   arbiter state encoding, default bus widths and the default
//   slave-ack timeout.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int unsigned ARB_ADDR_W  = 8;
   localparam int unsigned ARB_DATA_W  = 8;
   localparam int unsigned ARB_TIMEOUT = 15;
   localparam int unsigned ARB_CNT_W   = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
//   Slave-ack wait counter for the granted master.
//   Ports:
//     clk, rst  clock, synchronous active-high reset
//     clr       clear request (arbiter idle or no strobe pending)
//     inc       count this cycle (granted master strobing)
//     ack       slave acknowledge; clears the count and suppresses expiry
//     expired   count has reached TIMEOUT without an ack this cycle
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   input  logic ack,
   output logic expired
);

   localparam logic [ARB_CNT_W-1:0] LIMIT = ARB_CNT_W'(TIMEOUT);

   logic [ARB_CNT_W-1:0] cnt;

   // An ack on the limit cycle wins over the timeout.
   assign expired = (cnt == LIMIT) && !ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || ack || expired) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + ARB_CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master arbiter in front of a single data memory slave.
//   Master 0 is the core data port, master 1 the loader/debug port.
//   Ties in IDLE go to the master not granted last; a grant is held
//   for as long as the owner keeps cyc high, and every handover passes
//   through one IDLE cycle. A slave that does not ack within TIMEOUT
//   strobe cycles produces a one-cycle err to the granted master.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     mN_cyc_i/stb_i/we_i      master N bus cycle, strobe, write enable
//     mN_adr_i, mN_dat_i       master N address, write data
//     mN_ack_o, mN_err_o       master N acknowledge, timeout error
//     mN_gnt_o                 master N currently owns the bus
//     mN_dat_o                 read data (valid when qualified by ack)
//     s_cyc_o/stb_o/we_o       slave bus cycle, strobe, write enable
//     s_adr_o, s_dat_o         slave address, write data
//     s_ack_i, s_dat_i         slave acknowledge, read data
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ARB_ADDR_W,
   parameter int unsigned DATA_W  = ARB_DATA_W,
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic              m0_gnt_o,
   output logic [DATA_W-1:0] m0_dat_o,

   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              m1_gnt_o,
   output logic [DATA_W-1:0] m1_dat_o,

   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_adr_o,
   output logic [DATA_W-1:0] s_dat_o,
   input  logic              s_ack_i,
   input  logic [DATA_W-1:0] s_dat_i
);

   arb_state_t state;
   logic       last_gnt;     // 0: master 0 granted last, 1: master 1
   logic       sel_stb;      // strobe of the granted master, before timeout masking
   logic       tmr_clr;
   logic       tmr_expired;

   // ------------------------------------------------------------------
   // Grant state machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // Master 0 wins if alone, or on a tie when master 1 went last.
               if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                  state    <= GNT0;
                  last_gnt <= 1'b0;
               end else if (m1_cyc_i) begin
                  state    <= GNT1;
                  last_gnt <= 1'b1;
               end
            end
            GNT0: begin
               if (!m0_cyc_i) begin
                  state <= IDLE;
               end
            end
            GNT1: begin
               if (!m1_cyc_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Ack wait timer
   // ------------------------------------------------------------------
   assign sel_stb = ((state == GNT0) && m0_stb_i) ||
                    ((state == GNT1) && m1_stb_i);
   assign tmr_clr = (state == IDLE) || !sel_stb;

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .inc     (sel_stb),
      .ack     (s_ack_i),
      .expired (tmr_expired)
   );

   // ------------------------------------------------------------------
   // Bus muxing, purely a decode of the state register
   // ------------------------------------------------------------------
   always_comb begin
      s_cyc_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      m0_gnt_o = (state == GNT0);
      m1_gnt_o = (state == GNT1);

      case (state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = tmr_expired;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = tmr_expired;
         end
         default: begin
         end
      endcase

      // The timed-out strobe is withdrawn for one cycle so the slave
      // sees a fresh request when the master keeps strobing.
      s_stb_o = sel_stb && !tmr_expired;

      // Read data goes to both masters while the bus is owned; it is
      // held at zero in IDLE so nothing leaks out after reset.
      if (state != IDLE) begin
         m0_dat_o = s_dat_i;
         m1_dat_o = s_dat_i;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       m0_cyc_i, m0_stb_i, m0_we_i;
   logic [7:0] m0_adr_i, m0_dat_i;
   logic       m0_ack_o, m0_err_o, m0_gnt_o;
   logic [7:0] m0_dat_o;
   logic       m1_cyc_i, m1_stb_i, m1_we_i;
   logic [7:0] m1_adr_i, m1_dat_i;
   logic       m1_ack_o, m1_err_o, m1_gnt_o;
   logic [7:0] m1_dat_o;
   logic       s_cyc_o, s_stb_o, s_we_o;
   logic [7:0] s_adr_o, s_dat_o;
   logic       s_ack_i;
   logic [7:0] s_dat_i;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit         m;
      logic [7:0] d;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .TIMEOUT (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_cyc_i (m0_cyc_i),
      .m0_stb_i (m0_stb_i),
      .m0_we_i  (m0_we_i),
      .m0_adr_i (m0_adr_i),
      .m0_dat_i (m0_dat_i),
      .m0_ack_o (m0_ack_o),
      .m0_err_o (m0_err_o),
      .m0_gnt_o (m0_gnt_o),
      .m0_dat_o (m0_dat_o),
      .m1_cyc_i (m1_cyc_i),
      .m1_stb_i (m1_stb_i),
      .m1_we_i  (m1_we_i),
      .m1_adr_i (m1_adr_i),
      .m1_dat_i (m1_dat_i),
      .m1_ack_o (m1_ack_o),
      .m1_err_o (m1_err_o),
      .m1_gnt_o (m1_gnt_o),
      .m1_dat_o (m1_dat_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_ack_i  (s_ack_i),
      .s_dat_i  (s_dat_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every pushed entry must show up as an ack on the named
   // master with the given data; with nothing queued no ack may appear.
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_q.size() == 0) begin
            chk("no_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_sel", {30'd0, m1_ack_o, m0_ack_o}, e.m ? 32'd2 : 32'd1);
            chk("ack_dat", {24'd0, e.m ? m1_dat_o : m0_dat_o}, {24'd0, e.d});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #1;
   endtask

   task automatic drv0(input logic c, input logic s, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
      m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d;
   endtask

   task automatic drv1(input logic c, input logic s, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
      m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d;
   endtask

   task automatic mem(input logic a, input logic [7:0] d);
      s_ack_i = a; s_dat_i = d;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
      chk({tag, "_sctl"}, {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
      chk({tag, "_sbus"}, {16'd0, s_adr_o, s_dat_o}, 32'd0);
      chk({tag, "_ackerr"}, {28'd0, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}, 32'd0);
      chk({tag, "_mdat"}, {16'd0, m1_dat_o, m0_dat_o}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      drv0(0, 0, 0, 8'h00, 8'h00);
      drv1(0, 0, 0, 8'h00, 8'h00);
      mem(0, 8'h5A);
      step();
      step();
      rst = 1'b0;
      look();
      chk_all_zero(tag);
      mem(0, 8'h00);
   endtask

   logic [1:0] tie_exp [3];

   initial begin
      rst = 1'b1;
      drv0(0, 0, 0, 8'h00, 8'h00);
      drv1(0, 0, 0, 8'h00, 8'h00);
      mem(0, 8'h00);

      // Reset state
      do_reset("reset");

      // Tie rounds alternate starting with master 0
      tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
      for (int r = 0; r < 3; r++) begin
         step();
         m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
         look();
         chk("tie_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
         step();
         look();
         chk("tie_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, {30'd0, tie_exp[r]});
         m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      end
      step();
      look();
      chk("tie_end_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);

      // Basic read by master 0, slave acks two cycles after the grant
      do_reset("reset2");
      step();
      drv0(1, 1, 0, 8'h10, 8'h00);
      look();
      chk("rd_t_gnt", {31'd0, m0_gnt_o}, 32'd0);
      chk("rd_t_stb", {31'd0, s_stb_o}, 32'd0);
      step();
      look();
      chk("rd_t1_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd1);
      chk("rd_t1_sctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd6);
      chk("rd_t1_adr", {24'd0, s_adr_o}, 32'h10);
      step();
      look();
      chk("rd_wait_stb", {31'd0, s_stb_o}, 32'd1);
      step();
      mem(1, 8'hA5);
      exp_q.push_back('{m: 1'b0, d: 8'hA5});
      look();
      chk("rd_m1_dat_shared", {24'd0, m1_dat_o}, 32'hA5);
      chk("rd_m0_err", {31'd0, m0_err_o}, 32'd0);
      step();
      mem(0, 8'h00);
      drv0(0, 0, 0, 8'h00, 8'h00);
      look();
      chk("rd_drop_gnt", {31'd0, m0_gnt_o}, 32'd1);
      chk("rd_drop_scyc", {31'd0, s_cyc_o}, 32'd0);
      step();
      look();
      chk("rd_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);

      // Master 1 holds the bus for 5 writes while master 0 waits
      step();
      drv1(1, 1, 1, 8'h20, 8'h11);
      step();
      for (int i = 0; i < 5; i++) begin
         drv1(1, 1, 1, 8'h20 + 8'(i), 8'h11 + 8'(i));
         mem(1, 8'hC0 + 8'(i));
         exp_q.push_back('{m: 1'b1, d: 8'hC0 + 8'(i)});
         look();
         chk("wr_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd2);
         chk("wr_sctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd7);
         chk("wr_adr", {24'd0, s_adr_o}, {24'd0, 8'h20 + 8'(i)});
         chk("wr_dat", {24'd0, s_dat_o}, {24'd0, 8'h11 + 8'(i)});
         if (i == 0) drv0(1, 1, 0, 8'h30, 8'h00);
         step();
      end
      drv1(0, 0, 0, 8'h00, 8'h00);
      mem(0, 8'h00);
      look();
      chk("hold_drop", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd2);
      step();
      look();
      chk("hold_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
      step();
      look();
      chk("hold_m0_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd1);
      chk("hold_m0_adr", {24'd0, s_adr_o}, 32'h30);
      drv0(0, 0, 0, 8'h00, 8'h00);
      step();
      step();
      look();
      chk("hold_end_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);

      // Timeout with TIMEOUT=4: err every 5th strobe cycle, then an ack
      // that lands exactly on the timeout cycle
      step();
      drv0(1, 1, 0, 8'h40, 8'h00);
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) begin
            mem(1, 8'h3C);
            exp_q.push_back('{m: 1'b0, d: 8'h3C});
         end else begin
            mem(0, 8'h00);
         end
         look();
         chk("to_gnt", {31'd0, m0_gnt_o}, 32'd1);
         chk("to_err", {31'd0, m0_err_o}, (k == 5 || k == 10) ? 32'd1 : 32'd0);
         chk("to_stb", {31'd0, s_stb_o}, (k == 5 || k == 10) ? 32'd0 : 32'd1);
      end
      mem(0, 8'h00);
      drv0(0, 0, 0, 8'h00, 8'h00);
      step();
      step();
      look();
      chk("to_end_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);

      // Reset in the middle of a master 1 access with an ack on the way
      step();
      drv1(1, 1, 0, 8'h55, 8'h00);
      step();
      look();
      chk("rst_g1", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd2);
      step();
      rst = 1'b1;
      look();
      chk("rst_g1_hold", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd2);
      step();
      rst = 1'b0;
      m0_cyc_i = 1'b1;
      mem(1, 8'h99);
      look();
      chk_all_zero("rst_mid");
      mem(0, 8'h00);
      step();
      look();
      chk("rst_tie_m0", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd1);
      drv0(0, 0, 0, 8'h00, 8'h00);
      drv1(0, 0, 0, 8'h00, 8'h00);
      step();
      step();
      look();
      chk("final_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
      chk("sb_empty", exp_q.size(), 32'd0);

      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
